// File: rtl/div_issue_pkg.sv
// Shared definitions for the divide issue block and the iterative divider:
// sequencer state encodings, in_op bit positions and a sign-extension helper.
package div_issue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int OP_UNSIGNED = 0;
  localparam int OP_REM      = 1;
  localparam int OP_WORD     = 2;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_issue_special.sv
// Detects divide-by-zero and signed-overflow requests and forms their
// architectural result so the iterative divider can be skipped entirely.
module div_special
  import div_issue_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        special,
  output logic [63:0] result
);

  logic is_unsigned;
  logic is_rem;
  logic is_word;
  logic div_zero;
  logic overflow;

  always_comb begin
    is_unsigned = op[OP_UNSIGNED];
    is_rem      = op[OP_REM];
    is_word     = op[OP_WORD];

    div_zero = is_word ? (b[31:0] == 32'h0) : (b == 64'h0);
    overflow = !is_unsigned &&
               (is_word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    special  = div_zero || overflow;

    result = 64'h0;
    if (div_zero) begin
      result = is_rem ? (is_word ? sext32(a[31:0]) : a) : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (overflow) begin
      result = is_rem ? 64'h0 : (is_word ? sext32(a[31:0]) : a);
    end
  end

endmodule

// File: rtl/div_issue.sv
// Single-entry issue/writeback sequencer between the pipeline and an
// iterative divider; special cases retire directly without a divider trip.
//
//   state | meaning
//   IDLE  | ready to accept a new operation
//   ISSUE | presenting the request to the divider
//   WAIT  | divider busy, waiting for the result pulse
//   DRAIN | flushed while divider busy; swallow its next result
//   RESP  | result held on the writeback port
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             flush,
  output logic             div_req_valid,
  input  logic             div_req_ready,
  output logic [2:0]       div_op,
  output logic [63:0]      div_operand1,
  output logic [63:0]      div_operand2,
  input  logic             div_resp_valid,
  input  logic [63:0]      div_resp_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [63:0]      wb_result
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [63:0]      result_q, result_d;
  logic             wb_valid_q, wb_valid_d;
  logic             req_valid_q, req_valid_d;
  logic             spec_hit;
  logic [63:0]      spec_result;

  div_special u_special (
    .op      (in_op),
    .a       (in_a),
    .b       (in_b),
    .special (spec_hit),
    .result  (spec_result)
  );

  assign in_ready = (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d = in_op;
          a_d  = in_a;
          b_d  = in_b;
          rd_d = in_rd;
          if (spec_hit) begin
            result_d = spec_result;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_d = div_req_ready ? ST_DRAIN : ST_IDLE;
        end else if (div_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving with the flush is already consumed; draining would hang.
        if (div_resp_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            result_d = div_resp_result;
            state_d  = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (div_resp_valid) state_d = ST_IDLE;
      end
      ST_RESP: begin
        if (flush || wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    wb_valid_d  = (state_d == ST_RESP);
    req_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wb_valid_q  <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      req_valid_q <= req_valid_d;
    end
    op_q     <= op_d;
    a_q      <= a_d;
    b_q      <= b_d;
    rd_q     <= rd_d;
    result_q <= result_d;
  end

  assign div_req_valid = req_valid_q;
  assign div_op        = op_q;
  assign div_operand1  = a_q;
  assign div_operand2  = b_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = rd_q;
  assign wb_result     = result_q;

endmodule
